wall_depth_controller: RTL and testbench

- Sequences one wall "run" for the depth display and collision logic.
- Advances the wall depth by one step every FRAMES_PER_STEP video frames until MAX_WALL_DEPTH.
- At MAX_WALL_DEPTH, samples each active player's depth against the goal window, holds the result for HOLD_FRAMES, then ends the round.
- Drives wall_depth_in of the depth sprite and feeds the scoring/game FSM.

---
 rtl/wall_depth_controller.sv | 172 +++++++++++++++++
 tb/tb_wall_depth_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_depth_controller.sv
// Wall run sequencer: steps the wall depth per video frame, checks players against the goal window, holds, then ends the round.
// Optional build macro WALL_AUTO_RESTART_EN: HOLD loops straight back to ADVANCE instead of IDLE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no wall on screen, depth 0, waiting for start_in
// ADVANCE | wall moving, depth += 1 every FRAMES_PER_STEP unpaused frames
// CHECK   | single cycle, player depths sampled against the goal window
// HOLD    | depth parked at MAX_WALL_DEPTH for HOLD_FRAMES unpaused frames
module wall_depth_controller #(
  parameter int MAX_WALL_DEPTH   = 75,
  parameter int GOAL_DEPTH       = 60,
  parameter int GOAL_DEPTH_DELTA = 10,
  parameter int FRAMES_PER_STEP  = 4,
  parameter int HOLD_FRAMES      = 60
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       new_frame_in,
  input  logic       start_in,
  input  logic       pause_in,
  input  logic [1:0] num_players_in,
  input  logic [7:0] player_depths_in [3:0],
  output logic [7:0] wall_depth_out,
  output logic       wall_active_out,
  output logic       check_valid_out,
  output logic [3:0] player_in_goal_out,
  output logic       round_done_out,
  output logic [7:0] wall_count_out,
  output logic [1:0] state_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADVANCE = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam int CNT_MAX = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [7:0]       DEPTH_MAX = 8'(MAX_WALL_DEPTH);

  // Signed bounds so a delta wider than the goal clamps the lower edge at 0.
  localparam logic signed [9:0] WIN_LO_RAW = 10'(GOAL_DEPTH) - 10'(GOAL_DEPTH_DELTA);
  localparam logic signed [9:0] WIN_LO     = (WIN_LO_RAW < 0) ? 10'sd0 : WIN_LO_RAW;
  localparam logic signed [9:0] WIN_HI     = 10'(GOAL_DEPTH) + 10'(GOAL_DEPTH_DELTA);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       wall_depth_q, wall_depth_d;
  logic             wall_active_q, wall_active_d;
  logic             check_valid_q, check_valid_d;
  logic [3:0]       player_in_goal_q, player_in_goal_d;
  logic             round_done_q, round_done_d;
  logic [7:0]       wall_count_q, wall_count_d;

  logic             frame_tick;
  logic [3:0]       in_window;
  logic [1:0]       hold_exit_state;

  assign frame_tick = new_frame_in & ~pause_in;

`ifdef WALL_AUTO_RESTART_EN
  assign hold_exit_state = ADVANCE;
`else
  assign hold_exit_state = IDLE;
`endif

  always_comb begin
    in_window = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_window[i] = (i <= int'(num_players_in))
                  && ($signed({2'b00, player_depths_in[i]}) >= WIN_LO)
                  && ($signed({2'b00, player_depths_in[i]}) <= WIN_HI);
    end
  end

  always_comb begin
    state_d          = state_q;
    frame_cnt_d      = frame_cnt_q;
    wall_depth_d     = wall_depth_q;
    check_valid_d    = 1'b0;
    player_in_goal_d = player_in_goal_q;
    round_done_d     = 1'b0;
    wall_count_d     = wall_count_q;

    case (state_q)
      IDLE: begin
        wall_depth_d = 8'd0;
        if (start_in) begin
          state_d          = ADVANCE;
          frame_cnt_d      = '0;
          player_in_goal_d = 4'b0000;
        end
      end

      ADVANCE: begin
        if (frame_tick) begin
          if (frame_cnt_q == STEP_LAST) begin
            frame_cnt_d  = '0;
            wall_depth_d = wall_depth_q + 8'd1;
            if (wall_depth_q + 8'd1 == DEPTH_MAX) begin
              state_d = CHECK;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end

      CHECK: begin
        player_in_goal_d = in_window;
        check_valid_d    = 1'b1;
        frame_cnt_d      = '0;
        state_d          = HOLD;
      end

      HOLD: begin
        if (frame_tick) begin
          if (frame_cnt_q == HOLD_LAST) begin
            frame_cnt_d  = '0;
            wall_depth_d = 8'd0;
            round_done_d = 1'b1;
            state_d      = hold_exit_state;
            if (wall_count_q != 8'hFF) begin
              wall_count_d = wall_count_q + 8'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    wall_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= IDLE;
      frame_cnt_q      <= '0;
      wall_depth_q     <= 8'd0;
      wall_active_q    <= 1'b0;
      check_valid_q    <= 1'b0;
      player_in_goal_q <= 4'b0000;
      round_done_q     <= 1'b0;
      wall_count_q     <= 8'd0;
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      wall_depth_q     <= wall_depth_d;
      wall_active_q    <= wall_active_d;
      check_valid_q    <= check_valid_d;
      player_in_goal_q <= player_in_goal_d;
      round_done_q     <= round_done_d;
      wall_count_q     <= wall_count_d;
    end
  end

  assign wall_depth_out     = wall_depth_q;
  assign wall_active_out    = wall_active_q;
  assign check_valid_out    = check_valid_q;
  assign player_in_goal_out = player_in_goal_q;
  assign round_done_out     = round_done_q;
  assign wall_count_out     = wall_count_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_wall_depth_controller.sv
// Directed bench for wall_depth_controller with small parameters (MAX=5, GOAL=3, DELTA=1, 2 frames/step, 3 hold frames).
// Window is [2,4]; a normal round is 10 stepping frames plus 3 hold frames.
module tb_wall_depth_controller;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       new_frame_in;
  logic       start_in;
  logic       pause_in;
  logic [1:0] num_players_in;
  logic [7:0] player_depths_in [3:0];
  logic [7:0] wall_depth_out;
  logic       wall_active_out;
  logic       check_valid_out;
  logic [3:0] player_in_goal_out;
  logic       round_done_out;
  logic [7:0] wall_count_out;
  logic [1:0] state_out;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_done   = 0;
  int n_idle   = 0;

  wall_depth_controller #(
    .MAX_WALL_DEPTH(5), .GOAL_DEPTH(3), .GOAL_DEPTH_DELTA(1),
    .FRAMES_PER_STEP(2), .HOLD_FRAMES(3)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in),
    .start_in(start_in), .pause_in(pause_in), .num_players_in(num_players_in),
    .player_depths_in(player_depths_in), .wall_depth_out(wall_depth_out),
    .wall_active_out(wall_active_out), .check_valid_out(check_valid_out),
    .player_in_goal_out(player_in_goal_out), .round_done_out(round_done_out),
    .wall_count_out(wall_count_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (check_valid_out) n_valid++;
    if (round_done_out) n_done++;
    if (!wall_active_out) n_idle++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic frame();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    repeat (9) tick();
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic set_players(input logic [1:0] np, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    num_players_in      = np;
    player_depths_in[0] = d0;
    player_depths_in[1] = d1;
    player_depths_in[2] = d2;
    player_depths_in[3] = d3;
  endtask

  // Issues frames until a round_done pulse is seen; returns frames used, 0 on timeout.
  task automatic frames_until_done(output int nf);
    int done0;
    done0 = n_done;
    nf = 0;
    for (int i = 1; i <= 40; i++) begin
      frame();
      if (n_done != done0) begin
        nf = i;
        break;
      end
    end
  endtask

  task automatic fast_round(output bit ok);
    ok = 1'b0;
    start_pulse();
    new_frame_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (round_done_out) begin
        ok = 1'b1;
        break;
      end
    end
    new_frame_in = 1'b0;
    tick();
  endtask

  initial begin
    int nf;
    int done_before;
    int timeouts;
    bit ok;
    rst_n_in     = 1'b0;
    new_frame_in = 1'b0;
    start_in     = 1'b0;
    pause_in     = 1'b0;
    set_players(2'd0, 8'd3, 8'd0, 8'd0, 8'd0);
    repeat (3) tick();

    chk("rst_depth", wall_depth_out, 0);
    chk("rst_active", wall_active_out, 0);
    chk("rst_valid", check_valid_out, 0);
    chk("rst_goal", player_in_goal_out, 0);
    chk("rst_done", round_done_out, 0);
    chk("rst_count", wall_count_out, 0);
    chk("rst_state", state_out, 0);
    rst_n_in = 1'b1;
    repeat (2) tick();

`ifdef WALL_AUTO_RESTART_EN
    start_pulse();
    chk("ar_state_start", state_out, 1);
    n_idle = 0;
    for (int r = 1; r <= 3; r++) begin
      frames_until_done(nf);
      chk("ar_round_frames", nf, 13);
      chk("ar_state_after", state_out, 1);
      chk("ar_depth_after", wall_depth_out, 0);
      chk("ar_count", wall_count_out, r);
    end
    chk("ar_active_gaps", n_idle, 0);
    chk("ar_goal", player_in_goal_out, 4'b0001);
`else
    // Basic round, one player at depth 3.
    start_pulse();
    chk("t1_state_adv", state_out, 1);
    chk("t1_depth0", wall_depth_out, 0);
    chk("t1_active", wall_active_out, 1);
    for (int k = 1; k <= 10; k++) begin
      frame();
      chk("t1_depth_step", wall_depth_out, k / 2);
    end
    chk("t1_state_hold", state_out, 3);
    chk("t1_valid_pulses", n_valid, 1);
    chk("t1_goal", player_in_goal_out, 4'b0001);
    frame();
    frame();
    chk("t1_hold_depth", wall_depth_out, 5);
    chk("t1_no_done_yet", n_done, 0);
    frame();
    chk("t1_done_pulses", n_done, 1);
    chk("t1_count", wall_count_out, 1);
    chk("t1_depth_back", wall_depth_out, 0);
    chk("t1_state_idle", state_out, 0);
    chk("t1_goal_held", player_in_goal_out, 4'b0001);

    // Window edges with four players: 2 and 4 inside, 1 and 5 outside.
    set_players(2'd3, 8'd2, 8'd4, 8'd1, 8'd5);
    start_pulse();
    chk("t2_goal_cleared", player_in_goal_out, 0);
    frames_until_done(nf);
    chk("t2_frames", nf, 13);
    chk("t2_goal", player_in_goal_out, 4'b0011);
    chk("t2_valid_pulses", n_valid, 2);

    // Two active players; players 2 and 3 would be in window but are masked.
    set_players(2'd1, 8'd3, 8'd3, 8'd3, 8'd3);
    start_pulse();
    frames_until_done(nf);
    chk("t3_goal", player_in_goal_out, 4'b0011);
    chk("t3_count", wall_count_out, 3);

    // Start with a coincident frame: that frame must not be counted.
    start_in     = 1'b1;
    new_frame_in = 1'b1;
    tick();
    start_in     = 1'b0;
    new_frame_in = 1'b0;
    repeat (9) tick();
    frame();
    chk("t4_start_frame_dropped", wall_depth_out, 0);
    frame();
    chk("t4_first_step", wall_depth_out, 1);
    frame();
    start_pulse();
    chk("t4_start_ignored_state", state_out, 1);
    chk("t4_start_ignored_depth", wall_depth_out, 1);
    pause_in = 1'b1;
    repeat (4) frame();
    chk("t4_paused_depth", wall_depth_out, 1);
    pause_in = 1'b0;
    frames_until_done(nf);
    chk("t4_total_frames", 3 + 4 + nf, 17);
    chk("t4_count", wall_count_out, 4);

    // Async reset while holding.
    set_players(2'd0, 8'd3, 8'd0, 8'd0, 8'd0);
    start_pulse();
    repeat (11) frame();
    chk("t5_in_hold", state_out, 3);
    done_before = n_done;
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t5_rst_depth", wall_depth_out, 0);
    chk("t5_rst_state", state_out, 0);
    chk("t5_rst_active", wall_active_out, 0);
    chk("t5_rst_count", wall_count_out, 0);
    chk("t5_rst_goal", player_in_goal_out, 0);
    repeat (3) tick();
    rst_n_in = 1'b1;
    repeat (5) tick();
    chk("t5_no_done", n_done, done_before);
    chk("t5_stays_idle", state_out, 0);

    // Saturation of the round counter.
    timeouts = 0;
    for (int r = 0; r < 255; r++) begin
      fast_round(ok);
      if (!ok) timeouts++;
    end
    chk("t5_count_255", wall_count_out, 255);
    fast_round(ok);
    if (!ok) timeouts++;
    chk("t5_count_sat", wall_count_out, 255);
    chk("t5_round_timeouts", timeouts, 0);
    chk("t5_done_pulses", n_done - done_before, 256);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
